bsr_chain_param: RTL and testbench

//  Parametrised boundary-scan register: next generation of the fixed 9-in/5-out BSR.

---
 rtl/bsr_chain_param_if.sv | 48 ++++
 rtl/bsr_chain_param.sv | 154 +++++++++++++++
 tb/tb_bsr_chain_param.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bsr_chain_param_if.sv
// ---------------------------------------------------------------------------
// bsr_chain_param_if
//   Groups the TAP-side signals of the boundary-scan register: the serial
//   scan data pair and the DR strobes/instruction that the TAP controller
//   drives into the selected data register.
//
//   Signals
//     TDI         serial scan data into the chain
//     TDO         serial scan data out of the chain (driven by the BSR)
//     bsr_select  the BSR is the currently selected data register
//     dr_capture  TAP is in Capture-DR
//     dr_shift    TAP is in Shift-DR
//     dr_update   TAP is in Update-DR
//     instr       decoded boundary-scan instruction
//
//   Modports
//     master  TAP controller side (drives strobes and TDI, reads TDO)
//     slave   boundary-scan register side
// ---------------------------------------------------------------------------
interface bsr_chain_param_if;
  logic       TDI;
  logic       TDO;
  logic       bsr_select;
  logic       dr_capture;
  logic       dr_shift;
  logic       dr_update;
  logic [2:0] instr;

  modport master (
    output TDI,
    output bsr_select,
    output dr_capture,
    output dr_shift,
    output dr_update,
    output instr,
    input  TDO
  );

  modport slave (
    input  TDI,
    input  bsr_select,
    input  dr_capture,
    input  dr_shift,
    input  dr_update,
    input  instr,
    output TDO
  );
endinterface

// File: rtl/bsr_chain_param.sv
// ---------------------------------------------------------------------------
// bsr_chain_param
//   Parametrised boundary-scan register sitting between the TAP controller
//   and the pad ring. It holds one scan cell per input pin, one per output
//   pin and one output-enable control cell per group of G output pins, each
//   backed by an update register. The instruction selects whether the pads
//   and core see functional values or the update registers.
//
//   Scan order: TDI -> IN[NUM_IN-1..0] -> OUT[NUM_OUT-1..0]
//                   -> OE[NUM_OE-1..0] -> TDO
//
//   Ports
//     TCK                        clock, all state changes on posedge
//     TRST                       synchronous active-high reset
//     tap                        TAP side (TDI/TDO, strobes, instruction)
//     parallel_in                values from the input pads
//     to_system_logic            values presented to the core
//     parallel_system_logic_out  core output data
//     system_oe                  core output enables
//     to_output_pin              data driven to the output pads
//     output_pin_oe              enables driven to the output pads
//     shift_count                bits shifted since the last capture,
//                                saturating at the chain length
// ---------------------------------------------------------------------------
module bsr_chain_param #(
  parameter int NUM_IN  = 9,
  parameter int NUM_OUT = 5,
  parameter int NUM_OE  = 1,
  parameter int CW      = $clog2(NUM_IN + NUM_OUT + NUM_OE + 1)
) (
  input  logic                TCK,
  input  logic                TRST,
  bsr_chain_param_if.slave    tap,
  input  logic [NUM_IN-1:0]   parallel_in,
  output logic [NUM_IN-1:0]   to_system_logic,
  input  logic [NUM_OUT-1:0]  parallel_system_logic_out,
  input  logic [NUM_OUT-1:0]  system_oe,
  output logic [NUM_OUT-1:0]  to_output_pin,
  output logic [NUM_OUT-1:0]  output_pin_oe,
  output logic [CW-1:0]       shift_count
);

  localparam int L      = NUM_IN + NUM_OUT + NUM_OE;
  localparam int G      = NUM_OUT / NUM_OE;
  localparam int OUT_LO = NUM_OE;
  localparam int IN_LO  = NUM_OE + NUM_OUT;
  localparam logic [CW-1:0] LEN = CW'(L);

  typedef enum logic [2:0] {
    INSTR_SAMPLE = 3'd0,
    INSTR_EXTEST = 3'd1,
    INSTR_INTEST = 3'd2,
    INSTR_CLAMP  = 3'd3,
    INSTR_HIGHZ  = 3'd4
  } instr_e;

  // Each OE control cell governs an equal-sized group of output pins, so a
  // ragged split is a configuration error caught at elaboration.
  generate
    if (NUM_OUT % NUM_OE != 0) begin : g_bad_oe_grouping
      $error("bsr_chain_param: NUM_OUT must be a multiple of NUM_OE");
    end
  endgenerate

  // Scan and update registers are kept as one packed chain with IN in the
  // MSBs and OE[0] in bit 0, so a shift is a single right shift and TDO is
  // simply bit 0.
  logic [L-1:0]       scan_chain;
  logic [L-1:0]       upd_chain;
  logic [NUM_OE-1:0]  cap_oe;
  logic [L-1:0]       cap_chain;

  logic [NUM_IN-1:0]  upd_in;
  logic [NUM_OUT-1:0] upd_out;
  logic [NUM_OE-1:0]  upd_oe;
  logic [NUM_OUT-1:0] upd_oe_expanded;

  // Capture value for each OE control cell: a group is considered enabled
  // if any pin in it is enabled by the core.
  always_comb begin
    cap_oe = '0;
    for (int k = 0; k < NUM_OE; k++) begin
      cap_oe[k] = |system_oe[k*G +: G];
    end
  end

  assign cap_chain = {parallel_in, parallel_system_logic_out, cap_oe};

  // Scan, update and counter state. Capture wins over shift; update copies
  // the pre-edge scan value, so an update and a capture/shift on the same
  // edge do not interfere. Nothing moves unless the BSR is selected, and
  // reset overrides any strobe present on the same edge.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      scan_chain  <= '0;
      upd_chain   <= '0;
      shift_count <= '0;
    end else if (tap.bsr_select) begin
      if (tap.dr_capture) begin
        scan_chain  <= cap_chain;
        shift_count <= '0;
      end else if (tap.dr_shift) begin
        scan_chain <= {tap.TDI, scan_chain[L-1:1]};
        if (shift_count < LEN) begin
          shift_count <= shift_count + CW'(1);
        end
      end
      if (tap.dr_update) begin
        upd_chain <= scan_chain;
      end
    end
  end

  assign tap.TDO = scan_chain[0];

  assign upd_in  = upd_chain[IN_LO  +: NUM_IN];
  assign upd_out = upd_chain[OUT_LO +: NUM_OUT];
  assign upd_oe  = upd_chain[0      +: NUM_OE];

  // Fan each OE control cell out to the pins of its group.
  always_comb begin
    upd_oe_expanded = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      upd_oe_expanded[j] = upd_oe[j / G];
    end
  end

  // Pad and core muxes. Functional values pass through by default, which
  // also covers SAMPLE and the unused encodings 5-7.
  always_comb begin
    to_system_logic = parallel_in;
    to_output_pin   = parallel_system_logic_out;
    output_pin_oe   = system_oe;
    case (tap.instr)
      INSTR_EXTEST, INSTR_CLAMP: begin
        to_output_pin = upd_out;
        output_pin_oe = upd_oe_expanded;
      end
      INSTR_INTEST: begin
        to_system_logic = upd_in;
        to_output_pin   = upd_out;
        output_pin_oe   = upd_oe_expanded;
      end
      INSTR_HIGHZ: begin
        to_output_pin = upd_out;
        output_pin_oe = '0;
      end
      default: begin
        to_system_logic = parallel_in;
      end
    endcase
  end

endmodule

// File: tb/tb_bsr_chain_param.sv
// ---------------------------------------------------------------------------
// tb_bsr_chain_param
//   Directed testbench for bsr_chain_param with NUM_IN=4, NUM_OUT=4,
//   NUM_OE=2 (two output pins per OE control cell, chain length 10).
//   Expected values are hand-derived from the scan order
//   {IN[3:0], OUT[3:0], OE[1:0]} with OE[0] nearest TDO.
// ---------------------------------------------------------------------------
module tb_bsr_chain_param;

  localparam int NUM_IN  = 4;
  localparam int NUM_OUT = 4;
  localparam int NUM_OE  = 2;
  localparam int CW      = 4;

  logic               TCK;
  logic               TRST;
  logic [NUM_IN-1:0]  parallel_in;
  logic [NUM_IN-1:0]  to_system_logic;
  logic [NUM_OUT-1:0] parallel_system_logic_out;
  logic [NUM_OUT-1:0] system_oe;
  logic [NUM_OUT-1:0] to_output_pin;
  logic [NUM_OUT-1:0] output_pin_oe;
  logic [CW-1:0]      shift_count;

  int checkCount;
  int errorCount;

  bsr_chain_param_if tapIf ();

  bsr_chain_param #(
    .NUM_IN  (NUM_IN),
    .NUM_OUT (NUM_OUT),
    .NUM_OE  (NUM_OE),
    .CW      (CW)
  ) dut (
    .TCK                       (TCK),
    .TRST                      (TRST),
    .tap                       (tapIf),
    .parallel_in               (parallel_in),
    .to_system_logic           (to_system_logic),
    .parallel_system_logic_out (parallel_system_logic_out),
    .system_oe                 (system_oe),
    .to_output_pin             (to_output_pin),
    .output_pin_oe             (output_pin_oe),
    .shift_count               (shift_count)
  );

  // Free-running TCK, 10 time-unit period.
  initial begin
    TCK = 1'b0;
    forever #5 TCK = ~TCK;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Waits for the next rising edge and lets outputs settle.
  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  // One TCK cycle with the given strobes and TDI; strobes drop afterwards.
  task automatic applyStimulus(input logic cap, input logic shf,
                               input logic upd, input logic tdi);
    tapIf.dr_capture = cap;
    tapIf.dr_shift   = shf;
    tapIf.dr_update  = upd;
    tapIf.TDI        = tdi;
    tick();
    tapIf.dr_capture = 1'b0;
    tapIf.dr_shift   = 1'b0;
    tapIf.dr_update  = 1'b0;
    tapIf.TDI        = 1'b0;
  endtask

  // Shifts a full chain image in, bit 0 first, so bit 0 lands in OE[0].
  task automatic shiftVector(input logic [9:0] vec);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, vec[i]);
    end
  endtask

  logic [9:0] expTdo;
  logic       scanNonZero;

  initial begin
    checkCount = 0;
    errorCount = 0;

    TRST                      = 1'b1;
    tapIf.TDI                 = 1'b0;
    tapIf.bsr_select          = 1'b0;
    tapIf.dr_capture          = 1'b0;
    tapIf.dr_shift            = 1'b0;
    tapIf.dr_update           = 1'b0;
    tapIf.instr               = 3'd0;
    parallel_in               = 4'hA;
    parallel_system_logic_out = 4'h6;
    system_oe                 = 4'b1001;

    // Reset and SAMPLE pass-through.
    tick();
    tick();
    TRST = 1'b0;
    checkOutput("rst_tsl",   32'(to_system_logic), 32'hA);
    checkOutput("rst_tdo",   32'(tapIf.TDO),       32'h0);
    checkOutput("rst_count", 32'(shift_count),     32'h0);
    checkOutput("rst_pin",   32'(to_output_pin),   32'h6);
    checkOutput("rst_oe",    32'(output_pin_oe),   32'h9);

    // Capture (with shift also asserted: capture must win) then shift out.
    tapIf.bsr_select          = 1'b1;
    parallel_in               = 4'h5;
    parallel_system_logic_out = 4'h3;
    system_oe                 = 4'b0100;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("cap_count", 32'(shift_count), 32'h0);
    expTdo = 10'b0101_0011_10;
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("tdo_bit%0d", i), 32'(tapIf.TDO), 32'(expTdo[i]));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("count_10", 32'(shift_count), 32'd10);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("count_sat", 32'(shift_count), 32'd10);

    // EXTEST preload: OUT=C, OE=01; update regs are still zero until update.
    shiftVector({4'h0, 4'hC, 2'b01});
    tapIf.instr = 3'd1;
    #1;
    checkOutput("ext_pre_pin", 32'(to_output_pin), 32'h0);
    checkOutput("ext_pre_oe",  32'(output_pin_oe), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ext_pin", 32'(to_output_pin),   32'hC);
    checkOutput("ext_oe",  32'(output_pin_oe),   32'h3);
    checkOutput("ext_tsl", 32'(to_system_logic), 32'h5);

    // INTEST: load IN=9, pins must hold during the shift.
    for (int i = 0; i < 10; i++) begin
      logic [9:0] vec;
      vec = {4'h9, 4'hC, 2'b01};
      applyStimulus(1'b0, 1'b1, 1'b0, vec[i]);
      if (i == 4) begin
        checkOutput("hold_pin", 32'(to_output_pin), 32'hC);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tapIf.instr = 3'd2;
    parallel_in = 4'h0;
    #1;
    checkOutput("int_tsl_a", 32'(to_system_logic), 32'h9);
    parallel_in = 4'hF;
    #1;
    checkOutput("int_tsl_b", 32'(to_system_logic), 32'h9);
    checkOutput("int_pin",   32'(to_output_pin),   32'hC);
    checkOutput("int_oe",    32'(output_pin_oe),   32'h3);

    // HIGHZ then back to EXTEST; unused encoding behaves as SAMPLE.
    tapIf.instr = 3'd4;
    #1;
    checkOutput("hz_oe",  32'(output_pin_oe),   32'h0);
    checkOutput("hz_pin", 32'(to_output_pin),   32'hC);
    checkOutput("hz_tsl", 32'(to_system_logic), 32'hF);
    tapIf.instr = 3'd1;
    #1;
    checkOutput("ext_back_oe", 32'(output_pin_oe), 32'h3);
    tapIf.instr = 3'd6;
    #1;
    checkOutput("instr6_oe", 32'(output_pin_oe), 32'h4);

    // Reset after 5 of 10 shifts, with a shift strobe on the reset edge.
    tapIf.instr = 3'd1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    end
    checkOutput("mid_count", 32'(shift_count), 32'd5);
    TRST             = 1'b1;
    tapIf.dr_shift   = 1'b1;
    tapIf.TDI        = 1'b1;
    tick();
    TRST             = 1'b0;
    tapIf.dr_shift   = 1'b0;
    tapIf.TDI        = 1'b0;
    checkOutput("mrst_count", 32'(shift_count),   32'h0);
    checkOutput("mrst_tdo",   32'(tapIf.TDO),     32'h0);
    checkOutput("mrst_pin",   32'(to_output_pin), 32'h0);
    checkOutput("mrst_oe",    32'(output_pin_oe), 32'h0);

    // Deselected strobes change nothing.
    tapIf.bsr_select          = 1'b0;
    parallel_in               = 4'hF;
    parallel_system_logic_out = 4'hF;
    system_oe                 = 4'hF;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("desel_count", 32'(shift_count),   32'h0);
    checkOutput("desel_tdo",   32'(tapIf.TDO),     32'h0);
    checkOutput("desel_pin",   32'(to_output_pin), 32'h0);
    checkOutput("desel_oe",    32'(output_pin_oe), 32'h0);

    // Whole scan chain must be zero after reset.
    tapIf.bsr_select = 1'b1;
    scanNonZero = 1'b0;
    for (int i = 0; i < 10; i++) begin
      scanNonZero = scanNonZero | tapIf.TDO;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("scan_zero", 32'(scanNonZero), 32'h0);

    // Update followed directly by capture sees fresh pins.
    parallel_in               = 4'h3;
    parallel_system_logic_out = 4'hA;
    system_oe                 = 4'b0011;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("fresh_tdo", 32'(tapIf.TDO), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
